// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce, one latch pulse per press
module keypad_scanner #(
    parameter int SCAN_DIV       = 50_000,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] user_digit,
    output logic       user_latch,
    output logic       key_held
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LIM   = CW'(DEBOUNCE_TICKS);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    rs_meta_q, rs_q;
    logic [PW-1:0] presc_q;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]    col_q, col_d;
    logic [1:0]    row_q, row_d;
    logic [1:0]    first_row;
    logic [3:0]    digit_q, digit_d;
    logic          latch_q, latch_d;
    logic          held_q, held_d;
    logic          tick;
    logic          accept;
    logic [1:0]    acc_row;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'd0:    key_map = 4'h1;
            4'd1:    key_map = 4'h2;
            4'd2:    key_map = 4'h3;
            4'd3:    key_map = 4'hA;
            4'd4:    key_map = 4'h4;
            4'd5:    key_map = 4'h5;
            4'd6:    key_map = 4'h6;
            4'd7:    key_map = 4'hB;
            4'd8:    key_map = 4'h7;
            4'd9:    key_map = 4'h8;
            4'd10:   key_map = 4'h9;
            4'd11:   key_map = 4'hC;
            4'd12:   key_map = 4'hE;
            4'd13:   key_map = 4'h0;
            4'd14:   key_map = 4'hF;
            default: key_map = 4'hD;
        endcase
    endfunction

    assign tick    = (presc_q == PRESC_MAX);
    assign cnt_inc = (cnt_q == CNT_LIM) ? cnt_q : cnt_q + CW'(1);

    // Lowest-index low row wins when several rows are low.
    always_comb begin
        first_row = 2'd3;
        if (!rs_q[0])      first_row = 2'd0;
        else if (!rs_q[1]) first_row = 2'd1;
        else if (!rs_q[2]) first_row = 2'd2;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= SCAN;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs_meta_q <= 4'hF;
            rs_q      <= 4'hF;
            presc_q   <= '0;
            cnt_q     <= '0;
            col_q     <= 2'd0;
            row_q     <= 2'd0;
            digit_q   <= 4'h0;
            latch_q   <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            rs_meta_q <= row_in;
            rs_q      <= rs_meta_q;
            presc_q   <= tick ? '0 : presc_q + PW'(1);
            cnt_q     <= cnt_d;
            col_q     <= col_d;
            row_q     <= row_d;
            digit_q   <= digit_d;
            latch_q   <= latch_d;
            held_q    <= held_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        row_d   = row_q;
        digit_d = digit_q;
        latch_d = 1'b0;
        held_d  = held_q;
        accept  = 1'b0;
        acc_row = row_q;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (rs_q == 4'hF) begin
                        col_d = col_q + 2'd1;
                    end else begin
                        row_d = first_row;
                        if (DEBOUNCE_TICKS == 1) begin
                            accept  = 1'b1;
                            acc_row = first_row;
                        end else begin
                            cnt_d   = CW'(1);
                            state_d = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (!rs_q[row_q]) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_LIM) accept = 1'b1;
                    end else begin
                        state_d = SCAN;
                        col_d   = col_q + 2'd1;
                        cnt_d   = '0;
                    end
                end
                PRESSED: begin
                    // Column stays frozen; only the captured row's release is tracked.
                    if (rs_q[row_q]) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_LIM) begin
                            held_d  = 1'b0;
                            cnt_d   = '0;
                            state_d = SCAN;
                            col_d   = col_q + 2'd1;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
        if (accept) begin
            digit_d = key_map(acc_row, col_q);
            latch_d = 1'b1;
            held_d  = 1'b1;
            cnt_d   = '0;
            state_d = PRESSED;
        end
    end

    always_comb begin
        col_out        = 4'hF;
        col_out[col_q] = 1'b0;
        user_digit     = digit_q;
        user_latch     = latch_q;
        key_held       = held_q;
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner with a physical keypad model
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DT = 3;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] user_digit;
    logic       user_latch;
    logic       key_held;
    logic [15:0] keys = 16'h0;   // keys[row*4+col] = key physically pressed

    localparam logic [3:0] KMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                         4'h4, 4'h5, 4'h6, 4'hB,
                                         4'h7, 4'h8, 4'h9, 4'hC,
                                         4'hE, 4'h0, 4'hF, 4'hD};

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_TICKS(DT)) dut (
        .clk(clk), .reset(reset), .row_in(row_in), .col_out(col_out),
        .user_digit(user_digit), .user_latch(user_latch), .key_held(key_held)
    );

    always #5 clk = ~clk;

    // A row reads low when any pressed key on it sits in a driven (low) column.
    always_comb begin
        for (int r = 0; r < 4; r++) row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
    end

    int         m_cyc, m_mode, m_col, m_row, m_cnt;
    logic [3:0] m_s1, m_s2, m_digit;
    logic       m_latch, m_held;

    always @(posedge clk or negedge reset) begin : model
        logic [3:0] rs;
        logic       acc;
        if (!reset) begin
            m_cyc = 0; m_mode = 0; m_col = 0; m_row = 0; m_cnt = 0;
            m_s1 = 4'hF; m_s2 = 4'hF; m_digit = 4'h0; m_latch = 1'b0; m_held = 1'b0;
        end else begin
            rs = m_s2;
            m_latch = 1'b0;
            acc = 1'b0;
            if (m_cyc % SD == SD - 1) begin
                if (m_mode == 0) begin
                    if (rs == 4'hF) m_col = (m_col + 1) % 4;
                    else begin
                        for (int r = 3; r >= 0; r--) if (!rs[r]) m_row = r;
                        m_cnt = 1; m_mode = 1;
                        if (m_cnt >= DT) acc = 1'b1;
                    end
                end else if (m_mode == 1) begin
                    if (!rs[m_row]) begin
                        m_cnt++;
                        if (m_cnt >= DT) acc = 1'b1;
                    end else begin
                        m_mode = 0; m_col = (m_col + 1) % 4; m_cnt = 0;
                    end
                end else begin
                    if (rs[m_row]) begin
                        m_cnt++;
                        if (m_cnt >= DT) begin
                            m_held = 1'b0; m_cnt = 0; m_mode = 0; m_col = (m_col + 1) % 4;
                        end
                    end else m_cnt = 0;
                end
                if (acc) begin
                    m_digit = KMAP[m_row*4 + m_col];
                    m_latch = 1'b1; m_held = 1'b1; m_cnt = 0; m_mode = 2;
                end
            end
            m_cyc++;
            m_s2 = m_s1;
            m_s1 = row_in;
        end
    end

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    logic [3:0] digits [$];

    function automatic logic [3:0] col_pat(input int c);
        logic [3:0] p;
        p = 4'hF;
        p[c] = 1'b0;
        return p;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("cycle", {22'd0, col_out, user_digit, user_latch, key_held},
                  {22'd0, col_pat(m_col), m_digit, m_latch, m_held});
            if (user_latch === 1'b1) begin
                pulses++;
                digits.push_back(user_digit);
            end
        end
    endtask

    task automatic press_release(input int idx);
        keys = 16'h0;
        keys[idx] = 1'b1;
        step(100);
        keys = 16'h0;
        step(60);
    endtask

    initial begin
        int p0;
        int found;
        step(3);
        check("reset_outputs", {22'd0, col_out, user_digit, user_latch, key_held}, {22'd0, 4'b1110, 4'h0, 1'b0, 1'b0});
        reset = 1'b1;

        // 1: idle scan walks the columns, 4 clocks each
        for (int k = 0; k <= 16; k++) begin
            check("idle_scan", {26'd0, col_out, user_latch, key_held}, {26'd0, col_pat((k / 4) % 4), 2'b00});
            step(1);
        end

        // 2: hold key 5
        p0 = pulses;
        keys[5] = 1'b1;
        step(100);
        check("k5_pulses", pulses - p0, 1);
        check("k5_digit", user_digit, 4'h5);
        check("k5_held", key_held, 1'b1);
        step(40);
        check("k5_no_repeat", pulses - p0, 1);

        // 3: release then press again
        keys = 16'h0;
        step(60);
        check("k5_released", key_held, 1'b0);
        keys[5] = 1'b1;
        step(100);
        check("k5_again_pulses", pulses - p0, 2);
        check("k5_again_digit", user_digit, 4'h5);
        keys = 16'h0;
        step(60);

        // 4: two-tick bounce on col0 row0, aligned to the column switch
        p0 = pulses;
        found = 0;
        for (int i = 0; i < 40 && col_out === 4'b1110; i++) step(1);
        for (int i = 0; i < 40 && found == 0; i++) begin
            step(1);
            if (col_out === 4'b1110) found = 1;
        end
        check("bounce_align", found, 1);
        keys[0] = 1'b1;
        step(7);
        keys = 16'h0;
        step(5);
        check("bounce_next_col", col_out, 4'b1101);
        step(40);
        check("bounce_no_pulse", pulses - p0, 0);

        // 5: keys 3 and 9 together on col2; then key 0 while held
        p0 = pulses;
        keys[2] = 1'b1;
        keys[10] = 1'b1;
        step(100);
        check("prio_pulses", pulses - p0, 1);
        check("prio_digit", user_digit, 4'h3);
        keys[13] = 1'b1;
        step(60);
        check("held_ignore_pulses", pulses - p0, 1);
        check("held_ignore_held", key_held, 1'b1);
        keys = 16'h0;
        step(60);

        // 6: reset in the middle of debouncing key 9
        p0 = pulses;
        keys[10] = 1'b1;
        for (int i = 0; i < 60 && m_mode != 1; i++) step(1);
        check("reach_debounce", m_mode, 1);
        reset = 1'b0;
        #1;
        check("midreset_outputs", {22'd0, col_out, user_digit, user_latch, key_held}, {22'd0, 4'b1110, 4'h0, 1'b0, 1'b0});
        step(3);
        keys = 16'h0;
        reset = 1'b1;
        step(20);
        check("midreset_no_pulse", pulses - p0, 0);
        press_release(0);
        press_release(1);
        press_release(2);
        press_release(4);
        check("seq_pulses", pulses - p0, 4);
        if (digits.size() >= 4) begin
            check("seq_d1", digits[digits.size()-4], 4'h1);
            check("seq_d2", digits[digits.size()-3], 4'h2);
            check("seq_d3", digits[digits.size()-2], 4'h3);
            check("seq_d4", digits[digits.size()-1], 4'h4);
        end

        // random presses, bounces and multi-key chords against the model
        for (int i = 0; i < 40; i++) begin
            keys = 16'h0;
            case ($urandom_range(0, 3))
                0: ;
                1: keys[$urandom_range(0, 15)] = 1'b1;
                2: begin
                    keys[$urandom_range(0, 15)] = 1'b1;
                    keys[$urandom_range(0, 15)] = 1'b1;
                end
                default: keys = 16'($urandom);
            endcase
            step($urandom_range(1, 40));
        end
        keys = 16'h0;
        step(60);
        check("random_end_released", key_held, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
